local_mem_burst_splitter: RTL and testbench

- Avalon-MM burst adapter between AFU-side local-memory masters and the platform local-memory channel.
- Splits any source burst (up to the platform burst-count width) into fragments no longer than the sink's maximum burst.
- Read data and readdatavalid pass straight through, in order, unmodified.
- Uses the line-address, data and byte-mask types from local_mem_cfg_pkg.

---
 rtl/local_mem_cfg_pkg.sv | 48 ++++
 rtl/local_mem_burst_frag_counter.sv | 57 +++++
 rtl/local_mem_burst_splitter.sv | 167 ++++++++++++++++
 tb/tb_local_mem_burst_splitter.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/local_mem_cfg_pkg.sv
// Local-memory configuration package: line-address, data, mask and burst-count
// types, the burst-splitter state/operation enums, and the fragment-length helper.
// LOCAL_MEM_BURST_SPLIT_ALIGN_EN: when defined, fragments are naturally aligned
// to MAX_SINK-line boundaries; when undefined, fragments are MAX_SINK long
// except the last.
package local_mem_cfg_pkg;

  localparam int LOCAL_MEM_ADDR_WIDTH           = 27;
  localparam int LOCAL_MEM_DATA_WIDTH           = 64;
  localparam int LOCAL_MEM_BURST_CNT_WIDTH      = 7;
  localparam int LOCAL_MEM_SINK_BURST_CNT_WIDTH = 3;

  typedef logic [LOCAL_MEM_ADDR_WIDTH-1:0]           t_local_mem_addr;
  typedef logic [LOCAL_MEM_DATA_WIDTH-1:0]           t_local_mem_data;
  typedef logic [LOCAL_MEM_DATA_WIDTH/8-1:0]         t_local_mem_byte_mask;
  typedef logic [LOCAL_MEM_BURST_CNT_WIDTH-1:0]      t_local_mem_burst_cnt;
  typedef logic [LOCAL_MEM_SINK_BURST_CNT_WIDTH-1:0] t_local_mem_sink_burst_cnt;

  typedef enum logic [1:0] {
    IDLE,
    RD_SPLIT,
    WR_BURST
  } t_split_state;

  typedef enum logic [1:0] {
    CNT_HOLD,
    CNT_LOAD,
    CNT_RD_ADV,
    CNT_WR_BEAT
  } t_frag_cnt_op;

  // Length of the next fragment starting at addr with 'remaining' beats left.
  // max_sink must be a power of two.
  function automatic t_local_mem_burst_cnt local_mem_frag_len(
    input t_local_mem_addr      addr,
    input t_local_mem_burst_cnt remaining,
    input t_local_mem_burst_cnt max_sink
  );
    t_local_mem_burst_cnt room;
`ifdef LOCAL_MEM_BURST_SPLIT_ALIGN_EN
    room = max_sink - (t_local_mem_burst_cnt'(addr) & (max_sink - t_local_mem_burst_cnt'(1)));
`else
    room = max_sink;
`endif
    return (remaining < room) ? remaining : room;
  endfunction

endpackage

// File: rtl/local_mem_burst_frag_counter.sv
// Fragment bookkeeping shared by the read-split and write-burst paths:
// next fragment address, beats left in the source burst, beats left in the
// current write fragment.
module local_mem_burst_frag_counter
  import local_mem_cfg_pkg::*;
#(
  parameter int ADDR_WIDTH = LOCAL_MEM_ADDR_WIDTH,
  parameter int CNT_WIDTH  = LOCAL_MEM_BURST_CNT_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  t_frag_cnt_op          op,
  input  logic [ADDR_WIDTH-1:0] ld_addr,
  input  logic [CNT_WIDTH-1:0]  ld_total,
  input  logic [CNT_WIDTH-1:0]  ld_frag,
  input  logic [CNT_WIDTH-1:0]  frag_len,
  output logic [ADDR_WIDTH-1:0] cur_addr,
  output logic [CNT_WIDTH-1:0]  total_rem
);

  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

  logic [CNT_WIDTH-1:0] frag_rem;

  // Load on the first accepted beat, then advance per accepted fragment/beat.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cur_addr  <= '0;
      total_rem <= '0;
      frag_rem  <= '0;
    end else begin
      case (op)
        CNT_LOAD: begin
          cur_addr  <= ld_addr;
          total_rem <= ld_total;
          frag_rem  <= ld_frag;
        end
        CNT_RD_ADV: begin
          cur_addr  <= cur_addr + ADDR_WIDTH'(frag_len);
          total_rem <= total_rem - frag_len;
        end
        CNT_WR_BEAT: begin
          total_rem <= total_rem - CNT_ONE;
          // An empty fragment means this beat opens the next one.
          if (frag_rem == '0) begin
            frag_rem <= frag_len - CNT_ONE;
            cur_addr <= cur_addr + ADDR_WIDTH'(frag_len);
          end else begin
            frag_rem <= frag_rem - CNT_ONE;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/local_mem_burst_splitter.sv
// Avalon-MM burst splitter: breaks source bursts into sink fragments of at most
// MAX_SINK beats. Command path is combinational; read data is a straight wire.
// LOCAL_MEM_BURST_SPLIT_ALIGN_EN: when defined, fragments never cross a
// MAX_SINK-line boundary.
//
// state    | meaning
// IDLE     | no split in progress; source command drives the sink directly
// RD_SPLIT | issuing the remaining read fragments, source held in wait
// WR_BURST | forwarding write beats, re-addressing at fragment boundaries
module local_mem_burst_splitter
  import local_mem_cfg_pkg::*;
#(
  parameter int ADDR_WIDTH           = LOCAL_MEM_ADDR_WIDTH,
  parameter int DATA_WIDTH           = LOCAL_MEM_DATA_WIDTH,
  parameter int SRC_BURST_CNT_WIDTH  = LOCAL_MEM_BURST_CNT_WIDTH,
  parameter int SINK_BURST_CNT_WIDTH = 3
) (
  input  logic                            clk,
  input  logic                            reset_n,
  output logic                            src_waitrequest,
  input  logic                            src_read,
  input  logic                            src_write,
  input  logic [ADDR_WIDTH-1:0]           src_address,
  input  logic [SRC_BURST_CNT_WIDTH-1:0]  src_burstcount,
  input  logic [DATA_WIDTH-1:0]           src_writedata,
  input  logic [DATA_WIDTH/8-1:0]         src_byteenable,
  output logic [DATA_WIDTH-1:0]           src_readdata,
  output logic                            src_readdatavalid,
  input  logic                            sink_waitrequest,
  output logic                            sink_read,
  output logic                            sink_write,
  output logic [ADDR_WIDTH-1:0]           sink_address,
  output logic [SINK_BURST_CNT_WIDTH-1:0] sink_burstcount,
  output logic [DATA_WIDTH-1:0]           sink_writedata,
  output logic [DATA_WIDTH/8-1:0]         sink_byteenable,
  input  logic [DATA_WIDTH-1:0]           sink_readdata,
  input  logic                            sink_readdatavalid
);

  if (SINK_BURST_CNT_WIDTH > SRC_BURST_CNT_WIDTH) begin : g_bad_width
    $error("SINK_BURST_CNT_WIDTH must not exceed SRC_BURST_CNT_WIDTH");
  end

  localparam logic [SRC_BURST_CNT_WIDTH-1:0] MAX_SINK =
    SRC_BURST_CNT_WIDTH'(1) << (SINK_BURST_CNT_WIDTH - 1);
  localparam logic [SRC_BURST_CNT_WIDTH-1:0] CNT_ONE = SRC_BURST_CNT_WIDTH'(1);

  function automatic logic [SRC_BURST_CNT_WIDTH-1:0] frag_len(
    input logic [ADDR_WIDTH-1:0]          addr,
    input logic [SRC_BURST_CNT_WIDTH-1:0] rem
  );
    return SRC_BURST_CNT_WIDTH'(local_mem_frag_len(t_local_mem_addr'(addr),
                                                   t_local_mem_burst_cnt'(rem),
                                                   t_local_mem_burst_cnt'(MAX_SINK)));
  endfunction

  t_split_state                   state, state_nxt;
  t_frag_cnt_op                   cnt_op;
  logic [ADDR_WIDTH-1:0]          cur_addr, ld_addr;
  logic [SRC_BURST_CNT_WIDTH-1:0] total_rem, ld_total, ld_frag;
  logic [SRC_BURST_CNT_WIDTH-1:0] idle_len, cur_len;
  logic                           idle_split, wr_multi, rd_last, last_wbeat;

  assign src_readdata      = sink_readdata;
  assign src_readdatavalid = sink_readdatavalid;
  assign sink_writedata    = src_writedata;
  assign sink_byteenable   = src_byteenable;

  assign idle_len   = frag_len(src_address, src_burstcount);
  assign idle_split = src_read && (idle_len != src_burstcount);
  assign wr_multi   = src_write && (src_burstcount != CNT_ONE);
  assign cur_len    = frag_len(cur_addr, total_rem);
  assign rd_last    = (cur_len == total_rem);
  assign last_wbeat = (total_rem == CNT_ONE);

  local_mem_burst_frag_counter #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .CNT_WIDTH  (SRC_BURST_CNT_WIDTH)
  ) u_frag_counter (
    .clk       (clk),
    .reset_n   (reset_n),
    .op        (cnt_op),
    .ld_addr   (ld_addr),
    .ld_total  (ld_total),
    .ld_frag   (ld_frag),
    .frag_len  (cur_len),
    .cur_addr  (cur_addr),
    .total_rem (total_rem)
  );

  // State register; reset aborts any split in progress.
  always_ff @(posedge clk) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // Next-state decode on sink acceptance.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (idle_split && !sink_waitrequest)    state_nxt = RD_SPLIT;
        else if (wr_multi && !sink_waitrequest) state_nxt = WR_BURST;
      end
      RD_SPLIT: if (!sink_waitrequest && rd_last) state_nxt = IDLE;
      WR_BURST: if (src_write && !sink_waitrequest && last_wbeat) state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  // Sink command, source stall and counter control per state.
  always_comb begin
    sink_read       = src_read;
    sink_write      = src_write;
    sink_address    = src_address;
    sink_burstcount = SINK_BURST_CNT_WIDTH'(idle_len);
    src_waitrequest = sink_waitrequest;
    cnt_op          = CNT_HOLD;
    ld_addr         = src_address + ADDR_WIDTH'(idle_len);
    ld_total        = src_burstcount - idle_len;
    ld_frag         = idle_len - CNT_ONE;
    case (state)
      IDLE: begin
        if (idle_split) begin
          src_waitrequest = 1'b1;
          if (!sink_waitrequest) cnt_op = CNT_LOAD;
        end else if (wr_multi && !sink_waitrequest) begin
          cnt_op   = CNT_LOAD;
          ld_total = src_burstcount - CNT_ONE;
        end
      end
      RD_SPLIT: begin
        sink_read       = 1'b1;
        sink_write      = 1'b0;
        sink_address    = cur_addr;
        sink_burstcount = SINK_BURST_CNT_WIDTH'(cur_len);
        // Release the source only as its final fragment is taken.
        src_waitrequest = !(rd_last && !sink_waitrequest);
        if (!sink_waitrequest && !rd_last) cnt_op = CNT_RD_ADV;
      end
      WR_BURST: begin
        sink_read       = 1'b0;
        sink_address    = cur_addr;
        sink_burstcount = SINK_BURST_CNT_WIDTH'(cur_len);
        if (src_write && !sink_waitrequest) cnt_op = CNT_WR_BEAT;
      end
      default: ;
    endcase
    if (!reset_n && state != IDLE) begin
      sink_read  = 1'b0;
      sink_write = 1'b0;
    end
  end

`ifndef SYNTHESIS
  // Flag illegal source commands.
  always_ff @(posedge clk) begin
    if (reset_n) begin
      assert (!(src_read && src_write))
        else $error("src_read and src_write asserted together");
      assert (!((src_read || src_write) && src_burstcount == '0))
        else $error("src_burstcount of zero");
    end
  end
`endif

endmodule

// File: tb/tb_local_mem_burst_splitter.sv
// Directed bench for local_mem_burst_splitter: read splits, write fragments,
// pass-through, address wrap and mid-burst reset.
module tb_local_mem_burst_splitter;
  import local_mem_cfg_pkg::*;

  localparam int AW = LOCAL_MEM_ADDR_WIDTH;
  localparam int DW = LOCAL_MEM_DATA_WIDTH;
  localparam int BW = LOCAL_MEM_BURST_CNT_WIDTH;
  localparam int SW = 3;
  localparam logic [DW-1:0] RD_TAG = 64'hA5A5_0000_0000_0000;

  logic            clk = 1'b0;
  logic            reset_n;
  logic            src_waitrequest, src_read, src_write;
  logic [AW-1:0]   src_address;
  logic [BW-1:0]   src_burstcount;
  logic [DW-1:0]   src_writedata, src_readdata;
  logic [DW/8-1:0] src_byteenable;
  logic            src_readdatavalid;
  logic            sink_waitrequest = 1'b0;
  logic            sink_read, sink_write;
  logic [AW-1:0]   sink_address;
  logic [SW-1:0]   sink_burstcount;
  logic [DW-1:0]   sink_writedata;
  logic [DW/8-1:0] sink_byteenable;
  logic [DW-1:0]   sink_readdata = '0;
  logic            sink_readdatavalid = 1'b0;

  typedef struct {
    logic [AW-1:0]   addr;
    logic [SW-1:0]   bc;
    logic            wr;
    logic [DW-1:0]   data;
    logic [DW/8-1:0] be;
    logic            sw;
  } acc_t;

  acc_t          acc_q[$];
  int            n_checks = 0;
  int            n_errors = 0;
  int            rd_issued = 0, rd_sent = 0, rd_seen = 0;
  bit            stall_en = 1'b0;
  bit            hold_valid = 1'b0;
  logic [AW-1:0] hold_addr;
  logic [SW-1:0] hold_bc;

  local_mem_burst_splitter dut (
    .clk                (clk),
    .reset_n            (reset_n),
    .src_waitrequest    (src_waitrequest),
    .src_read           (src_read),
    .src_write          (src_write),
    .src_address        (src_address),
    .src_burstcount     (src_burstcount),
    .src_writedata      (src_writedata),
    .src_byteenable     (src_byteenable),
    .src_readdata       (src_readdata),
    .src_readdatavalid  (src_readdatavalid),
    .sink_waitrequest   (sink_waitrequest),
    .sink_read          (sink_read),
    .sink_write         (sink_write),
    .sink_address       (sink_address),
    .sink_burstcount    (sink_burstcount),
    .sink_writedata     (sink_writedata),
    .sink_byteenable    (sink_byteenable),
    .sink_readdata      (sink_readdata),
    .sink_readdatavalid (sink_readdatavalid)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Sink stall generator.
  always @(posedge clk) begin
    #1;
    sink_waitrequest = stall_en ? 1'($urandom_range(0, 1)) : 1'b0;
  end

  // Sink read responder: one beat per cycle for every accepted read beat.
  always @(posedge clk) begin
    #1;
    if (rd_sent < rd_issued) begin
      sink_readdatavalid = 1'b1;
      sink_readdata      = RD_TAG | DW'(rd_sent);
      rd_sent++;
    end else begin
      sink_readdatavalid = 1'b0;
    end
  end

  // Sink acceptance monitor.
  always @(negedge clk) begin
    if ((sink_read || sink_write) && !sink_waitrequest) begin
      acc_q.push_back('{addr: sink_address, bc: sink_burstcount, wr: sink_write,
                        data: sink_writedata, be: sink_byteenable, sw: src_waitrequest});
      if (sink_read) rd_issued += int'(sink_burstcount);
    end
  end

  // Read data returned to the source, in order.
  always @(negedge clk) begin
    if (src_readdatavalid) begin
      check("rdata", src_readdata, RD_TAG | DW'(rd_seen));
      rd_seen++;
    end
  end

  // A stalled read fragment must not change until accepted.
  always @(negedge clk) begin
    if (hold_valid && sink_read) begin
      check("hold_addr", 64'(sink_address), 64'(hold_addr));
      check("hold_bc", 64'(sink_burstcount), 64'(hold_bc));
    end
    hold_valid = sink_read && sink_waitrequest;
    hold_addr  = sink_address;
    hold_bc    = sink_burstcount;
  end

  // Called and returns at posedge+1.
  task automatic do_read(input logic [AW-1:0] a, input logic [BW-1:0] bc, input bit pt);
    bit done = 1'b0;
    int cyc  = 0;
    src_read       = 1'b1;
    src_address    = a;
    src_burstcount = bc;
    while (!done && cyc < 300) begin
      @(negedge clk);
      if (pt) check("pt_wait", 64'(src_waitrequest), 64'(sink_waitrequest));
      if (!src_waitrequest) done = 1'b1;
      @(posedge clk); #1;
      cyc++;
    end
    src_read = 1'b0;
    check("rd_done", 64'(done), 64'(1));
  endtask

  task automatic do_write(input logic [AW-1:0] a, input logic [BW-1:0] bc,
                          input int nbeats, input logic [DW-1:0] base);
    for (int i = 0; i < nbeats; i++) begin
      bit done = 1'b0;
      int cyc  = 0;
      src_write      = 1'b1;
      src_address    = a;
      src_burstcount = bc;
      src_writedata  = base + DW'(i);
      src_byteenable = 8'hF0 ^ 8'(i);
      while (!done && cyc < 300) begin
        @(negedge clk);
        check("wr_wait", 64'(src_waitrequest), 64'(sink_waitrequest));
        if (!src_waitrequest) done = 1'b1;
        @(posedge clk); #1;
        cyc++;
      end
      check("wr_done", 64'(done), 64'(1));
    end
    src_write = 1'b0;
  endtask

  task automatic check_frag(input string tag, input int idx, input logic [AW-1:0] a, input int bc);
    if (idx < acc_q.size()) begin
      check({tag, "_addr"}, 64'(acc_q[idx].addr), 64'(a));
      check({tag, "_bc"}, 64'(acc_q[idx].bc), 64'(bc));
    end else begin
      check({tag, "_missing"}, 64'(acc_q.size()), 64'(idx + 1));
    end
  endtask

  task automatic wait_rd(input string tag, input int n, input int start);
    int cyc = 0;
    while (rd_seen - start < n && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
    end
    repeat (4) @(posedge clk);
    #1;
    check(tag, 64'(rd_seen - start), 64'(n));
  endtask

  task automatic check_wr_beats(input string tag, input int n, input logic [DW-1:0] base);
    check({tag, "_nbeats"}, 64'(acc_q.size()), 64'(n));
    for (int i = 0; i < n; i++) begin
      if (i < acc_q.size()) begin
        check({tag, "_wr"}, 64'(acc_q[i].wr), 64'(1));
        check({tag, "_data"}, acc_q[i].data, base + DW'(i));
        check({tag, "_be"}, 64'(acc_q[i].be), 64'(8'hF0 ^ 8'(i)));
      end
    end
  endtask

  initial begin
    int s;
    reset_n        = 1'b0;
    src_read       = 1'b0;
    src_write      = 1'b0;
    src_address    = '0;
    src_burstcount = '0;
    src_writedata  = '0;
    src_byteenable = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_src_wait", 64'(src_waitrequest), 64'(0));
    check("rst_sink_read", 64'(sink_read), 64'(0));
    check("rst_sink_write", 64'(sink_write), 64'(0));
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;

    // Read 8 @0x100, no stall.
    acc_q.delete();
    s = rd_seen;
    do_read(27'h100, 7'd8, 1'b0);
    check("t1_nfrag", 64'(acc_q.size()), 64'(2));
    check_frag("t1_f0", 0, 27'h100, 4);
    check_frag("t1_f1", 1, 27'h104, 4);
    if (acc_q.size() >= 2) begin
      check("t1_wait_f0", 64'(acc_q[0].sw), 64'(1));
      check("t1_wait_f1", 64'(acc_q[1].sw), 64'(0));
    end
    wait_rd("t1_rbeats", 8, s);

    // Read 5 @0x200, random stalls.
    acc_q.delete();
    s = rd_seen;
    stall_en = 1'b1;
    do_read(27'h200, 7'd5, 1'b0);
    stall_en = 1'b0;
    check("t2_nfrag", 64'(acc_q.size()), 64'(2));
    check_frag("t2_f0", 0, 27'h200, 4);
    check_frag("t2_f1", 1, 27'h204, 1);
    wait_rd("t2_rbeats", 5, s);

    // Write 6 @0x300, random stalls.
    acc_q.delete();
    stall_en = 1'b1;
    do_write(27'h300, 7'd6, 6, 64'h1000);
    stall_en = 1'b0;
    check_wr_beats("t3", 6, 64'h1000);
    check_frag("t3_b1", 0, 27'h300, 4);
    check_frag("t3_b5", 4, 27'h304, 2);

    // Pass-through read and write of 3 @0x10.
    acc_q.delete();
    s = rd_seen;
    stall_en = 1'b1;
    do_read(27'h10, 7'd3, 1'b1);
    check("t4r_nfrag", 64'(acc_q.size()), 64'(1));
    check_frag("t4r_f0", 0, 27'h10, 3);
    wait_rd("t4r_rbeats", 3, s);
    acc_q.delete();
    do_write(27'h10, 7'd3, 3, 64'h2000);
    stall_en = 1'b0;
    check_wr_beats("t4w", 3, 64'h2000);
    check_frag("t4w_b1", 0, 27'h10, 3);

    // Read 8 @0x102: alignment-dependent fragmentation.
    acc_q.delete();
    s = rd_seen;
    do_read(27'h102, 7'd8, 1'b0);
`ifdef LOCAL_MEM_BURST_SPLIT_ALIGN_EN
    check("t5_nfrag", 64'(acc_q.size()), 64'(3));
    check_frag("t5_f0", 0, 27'h102, 2);
    check_frag("t5_f1", 1, 27'h104, 4);
    check_frag("t5_f2", 2, 27'h108, 2);
`else
    check("t5_nfrag", 64'(acc_q.size()), 64'(2));
    check_frag("t5_f0", 0, 27'h102, 4);
    check_frag("t5_f1", 1, 27'h106, 4);
`endif
    wait_rd("t5_rbeats", 8, s);

    // Read 8 near the top of the address space: silent wrap.
    acc_q.delete();
    s = rd_seen;
    do_read(27'h7FF_FFFE, 7'd8, 1'b0);
`ifdef LOCAL_MEM_BURST_SPLIT_ALIGN_EN
    check("t6_nfrag", 64'(acc_q.size()), 64'(3));
    check_frag("t6_f0", 0, 27'h7FF_FFFE, 2);
    check_frag("t6_f1", 1, 27'h0, 4);
    check_frag("t6_f2", 2, 27'h4, 2);
`else
    check("t6_nfrag", 64'(acc_q.size()), 64'(2));
    check_frag("t6_f0", 0, 27'h7FF_FFFE, 4);
    check_frag("t6_f1", 1, 27'h2, 4);
`endif
    wait_rd("t6_rbeats", 8, s);

    // Reset at beat 3 of an 8-beat write, then a single-beat read.
    acc_q.delete();
    do_write(27'h500, 7'd8, 2, 64'h3000);
    check("t7_pre_nbeats", 64'(acc_q.size()), 64'(2));
    reset_n = 1'b0;
    @(negedge clk);
    check("t7_rst_sink_write", 64'(sink_write), 64'(0));
    check("t7_rst_sink_read", 64'(sink_read), 64'(0));
    @(posedge clk); #1;
    reset_n = 1'b1;
    acc_q.delete();
    s = rd_seen;
    do_read(27'h40, 7'd1, 1'b1);
    check("t7_nfrag", 64'(acc_q.size()), 64'(1));
    check_frag("t7_f0", 0, 27'h40, 1);
    if (acc_q.size() >= 1) check("t7_is_read", 64'(acc_q[0].wr), 64'(0));
    wait_rd("t7_rbeats", 1, s);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
